usec_timer_arbiter: RTL and testbench

//  Shares one microsecond delay engine (prescaler + countdown) between NUM_REQ requesters.

---
 rtl/usec_timer_arbiter.sv | 91 +++++++++
 tb/tb_usec_timer_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/usec_timer_arbiter.sv
// usec_timer_arbiter: one prescaled microsecond countdown shared by NUM_REQ requesters
// under rotating priority, with a one-cycle done pulse to the owner on expiry.
module usec_timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TICK_DIV = 50,
    parameter int CNT_W    = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     cnt_pulse,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_us,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q;
    logic [IW-1:0]      rr_ptr_q, owner_q, win;
    logic [PW-1:0]      presc_q;
    logic [CNT_W-1:0]   rem_q;
    logic [NUM_REQ-1:0] grant_q, done_q;
    logic               busy_q;
    logic [IW-1:0]      next_ptr;
    int                 idx;
    // Descending scan so the last hit is the set bit closest to rr_ptr.
    always_comb begin
        win = rr_ptr_q;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (req[idx]) win = IW'(idx);
        end
    end
    assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            presc_q  <= '0;
            rem_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    owner_q <= win;
                    rem_q   <= req_us[win*CNT_W +: CNT_W];
                    presc_q <= '0;
                    grant_q <= NUM_REQ'(1) << win;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: if (!req[owner_q]) begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= next_ptr;
                end else if (rem_q == '0) begin
                    state_q <= DONE;
                    done_q  <= grant_q;
                end else if (cnt_pulse) begin
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_q <= '0;
                        rem_q   <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= grant_q;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    done_q   <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= next_ptr;
                end
            endcase
        end
    end
    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_usec_timer_arbiter.sv
// tb_usec_timer_arbiter: directed scenario tasks with hand-computed expectations.
module tb_usec_timer_arbiter;
    localparam int N  = 4;
    localparam int CW = 16;
    logic sys_clk = 1'b0;
    logic sys_rst, cnt_pulse, busy;
    logic [N-1:0] req, grant, done;
    logic [N*CW-1:0] req_us;
    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    always #5 sys_clk = ~sys_clk;

    usec_timer_arbiter #(.NUM_REQ(N), .TICK_DIV(50), .CNT_W(CW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cnt_pulse(cnt_pulse),
        .req(req), .req_us(req_us), .grant(grant), .done(done), .busy(busy)
    );

    task automatic step();
        @(negedge sys_clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; req = '0; cnt_pulse = 1'b1; req_us = '0;
        step(); step();
        sys_rst = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done === '0 && n < limit) begin step(); n++; end
        if (done === '0) n = -1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req_us[0 +: CW] = 16'd3; req = 4'b0001;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        wait_done(1000, n);
        checks++; if (n != 150) begin errors++; $display("FAIL single_latency: got %0d expected 150", n); end
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", done); end
        req = 4'b0000;
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_off: got %b expected 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse: got %b expected 0000", done); end
    endtask

    task automatic test_round_robin();
        int n, prev;
        do_reset();
        for (int k = 0; k < N; k++) req_us[k*CW +: CW] = 16'd1;
        req = 4'b1111;
        prev = -1;
        for (int k = 0; k < N; k++) begin
            n = 0;
            while (grant === '0 && n < 20) begin step(); n++; end
            checks++; if (grant !== (N'(1) << k)) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, grant, N'(1) << k); end
            wait_done(200, n);
            checks++; if (n != 50) begin errors++; $display("FAIL rr_latency_%0d: got %0d expected 50", k, n); end
            if (k > 0) begin
                checks++; if (cyc_n - prev != 52) begin errors++; $display("FAIL rr_spacing_%0d: got %0d expected 52", k, cyc_n - prev); end
            end
            prev = cyc_n;
            req[k] = 1'b0;
            step();
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_idle_gap_%0d: got %b expected 0000", k, grant); end
        end
    endtask

    task automatic test_zero_delay();
        do_reset();
        req_us[2*CW +: CW] = 16'd0; req = 4'b0100;
        step();
        checks++; if ({grant, done, busy} !== {4'b0100, 4'b0000, 1'b1}) begin errors++; $display("FAIL zero_g: got %b/%b/%b expected 0100/0000/1", grant, done, busy); end
        step();
        checks++; if ({done, busy} !== {4'b0100, 1'b1}) begin errors++; $display("FAIL zero_done: got %b/%b expected 0100/1", done, busy); end
        req = 4'b0000;
        step();
        checks++; if ({grant, busy} !== {4'b0000, 1'b0}) begin errors++; $display("FAIL zero_idle: got %b/%b expected 0000/0", grant, busy); end
    endtask

    task automatic test_abort();
        int nd;
        do_reset();
        req_us[1*CW +: CW] = 16'd10; req = 4'b0010;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_grant: got %b expected 0010", grant); end
        req = 4'b0111;
        nd = 0;
        repeat (100) begin step(); if (done !== '0) nd++; end
        checks++; if (nd != 0) begin errors++; $display("FAIL abort_early_done: got %0d expected 0", nd); end
        req = 4'b0101;
        step();
        checks++; if ({grant, done} !== {4'b0000, 4'b0000}) begin errors++; $display("FAIL abort_release: got %b/%b expected 0000/0000", grant, done); end
        step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL abort_next: got %b expected 0100", grant); end
        req = 4'b0000;
    endtask

    task automatic test_pulse_gating();
        int n;
        do_reset();
        req_us[0 +: CW] = 16'd2; cnt_pulse = 1'b1; req = 4'b0001;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL gate_grant: got %b expected 0001", grant); end
        n = 0;
        while (done === '0 && n < 400) begin cnt_pulse = ~cnt_pulse; step(); n++; end
        checks++; if (n != 199 && n != 200) begin errors++; $display("FAIL gate_latency: got %0d expected 199 or 200", n); end
        req = 4'b0000; cnt_pulse = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        req_us[1*CW +: CW] = 16'd0; req = 4'b0010;
        step(); step();
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL rst_pre_done: got %b expected 0010", done); end
        req = 4'b0000;
        step();
        req_us[3*CW +: CW] = 16'd5; req = 4'b1000;
        step();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rst_pre_grant: got %b expected 1000", grant); end
        repeat (10) step();
        sys_rst = 1'b1; req = 4'b1001;
        step();
        sys_rst = 1'b0;
        checks++; if ({grant, done, busy} !== {4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL rst_mid_run: got %b/%b/%b expected 0000/0000/0", grant, done, busy); end
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_ptr: got %b expected 0001", grant); end
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_delay();
        test_abort();
        test_pulse_gating();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
